// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel/line counters, sync pulses, active-region
// decode and scaled framebuffer coordinates, all registered and mutually aligned.
module vga_timing #(
    parameter int CW        = 12,
    parameter int HFRONT    = 48,
    parameter int HSYNCP    = 112,
    parameter int HBACK     = 248,
    parameter int HLINE     = 1688,
    parameter int VFRONT    = 1,
    parameter int VSYNCP    = 3,
    parameter int VBACK     = 38,
    parameter int VFRAME    = 1066,
    parameter bit HSYNC_POL = 1'b1,
    parameter bit VSYNC_POL = 1'b1,
    parameter int XSCALE    = 1,
    parameter int YSCALE    = 1,
    parameter int FB_X_MAX  = 1280,
    parameter int FB_Y_MAX  = 1024
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic          hsync,
    output logic          vsync,
    output logic          active,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          fb_valid,
    output logic          sol,
    output logic          sof
);

    localparam int HSTART = HFRONT + HSYNCP + HBACK;
    localparam int VSTART = VFRONT + VSYNCP + VBACK;

    if (HSTART >= HLINE) begin : g_bad_hline
        $error("vga_timing: HFRONT+HSYNCP+HBACK must be less than HLINE");
    end
    if (VSTART >= VFRAME) begin : g_bad_vframe
        $error("vga_timing: VFRONT+VSYNCP+VBACK must be less than VFRAME");
    end
    if (XSCALE < 1 || XSCALE > 8 || YSCALE < 1 || YSCALE > 8) begin : g_bad_scale
        $error("vga_timing: XSCALE and YSCALE must lie in 1..8");
    end
    if (longint'(HLINE) > (longint'(1) << CW) || longint'(VFRAME) > (longint'(1) << CW)) begin : g_bad_cw
        $error("vga_timing: HLINE and VFRAME must not exceed 2**CW");
    end

    localparam logic [CW-1:0] H_LAST     = CW'(HLINE - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(VFRAME - 1);
    localparam logic [CW-1:0] H_SYNC_ON  = CW'(HFRONT);
    localparam logic [CW-1:0] H_SYNC_OFF = CW'(HFRONT + HSYNCP);
    localparam logic [CW-1:0] V_SYNC_ON  = CW'(VFRONT);
    localparam logic [CW-1:0] V_SYNC_OFF = CW'(VFRONT + VSYNCP);
    localparam logic [CW-1:0] H_ACT      = CW'(HSTART);
    localparam logic [CW-1:0] V_ACT      = CW'(VSTART);
    localparam logic [2:0]    XS_LAST    = 3'(XSCALE - 1);
    localparam logic [2:0]    YS_LAST    = 3'(YSCALE - 1);

    // Limits widened by one bit so a framebuffer as large as 2**CW still compares correctly.
    localparam logic [CW:0] FB_X_LIM = (longint'(FB_X_MAX) > (longint'(1) << CW)) ?
                                       {1'b1, {CW{1'b0}}} : (CW+1)'(FB_X_MAX);
    localparam logic [CW:0] FB_Y_LIM = (longint'(FB_Y_MAX) > (longint'(1) << CW)) ?
                                       {1'b1, {CW{1'b0}}} : (CW+1)'(FB_Y_MAX);

    logic [CW-1:0] h_q, h_d, v_q, v_d;
    logic [CW-1:0] xcnt_q, xcnt_d, ycnt_q, ycnt_d;
    logic [2:0]    xsub_q, xsub_d, ysub_q, ysub_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic          hsync_q, hsync_d, vsync_q, vsync_d;
    logic          active_q, active_d, fb_valid_q, fb_valid_d;
    logic          sol_q, sol_d, sof_q, sof_d;

    logic          line_wrap;
    logic [CW-1:0] h_n, v_n;
    logic          h_act_n, act_n;
    logic [CW-1:0] xcnt_n, ycnt_n, x_n, y_n;
    logic [2:0]    xsub_n, ysub_n;

    // Everything below is decoded from the position the counters move to, so the
    // registered outputs line up with the registered counters in the same cycle.
    always_comb begin : next_position
        line_wrap = (h_q == H_LAST);
        h_n       = line_wrap ? '0 : h_q + 1'b1;
        if (line_wrap) begin
            v_n = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end else begin
            v_n = v_q;
        end
        h_act_n = (h_n >= H_ACT);
        act_n   = h_act_n && (v_n >= V_ACT);
    end

    // NOTE: every variable gets a value on every path so no latch is inferred.
    always_comb begin : next_scale
        xcnt_n = '0;
        xsub_n = '0;
        if (h_act_n && (h_n != H_ACT)) begin
            if (xsub_q == XS_LAST) begin
                xcnt_n = (xcnt_q == '1) ? xcnt_q : xcnt_q + 1'b1;
            end else begin
                xsub_n = xsub_q + 1'b1;
                xcnt_n = xcnt_q;
            end
        end

        ycnt_n = ycnt_q;
        ysub_n = ysub_q;
        if (line_wrap) begin
            ycnt_n = '0;
            ysub_n = '0;
            if (v_n > V_ACT) begin
                if (ysub_q == YS_LAST) begin
                    ycnt_n = (ycnt_q == '1) ? ycnt_q : ycnt_q + 1'b1;
                end else begin
                    ysub_n = ysub_q + 1'b1;
                    ycnt_n = ycnt_q;
                end
            end
        end

        x_n = act_n ? xcnt_n : '0;
        y_n = act_n ? ycnt_n : '0;
    end

    always_comb begin : hold_or_advance
        h_d        = h_q;
        v_d        = v_q;
        xcnt_d     = xcnt_q;
        xsub_d     = xsub_q;
        ycnt_d     = ycnt_q;
        ysub_d     = ysub_q;
        x_d        = x_q;
        y_d        = y_q;
        hsync_d    = hsync_q;
        vsync_d    = vsync_q;
        active_d   = active_q;
        fb_valid_d = fb_valid_q;
        sol_d      = sol_q;
        sof_d      = sof_q;
        if (ce) begin
            h_d        = h_n;
            v_d        = v_n;
            xcnt_d     = xcnt_n;
            xsub_d     = xsub_n;
            ycnt_d     = ycnt_n;
            ysub_d     = ysub_n;
            x_d        = x_n;
            y_d        = y_n;
            hsync_d    = ((h_n >= H_SYNC_ON) && (h_n < H_SYNC_OFF)) ? HSYNC_POL : ~HSYNC_POL;
            vsync_d    = ((v_n >= V_SYNC_ON) && (v_n < V_SYNC_OFF)) ? VSYNC_POL : ~VSYNC_POL;
            active_d   = act_n;
            fb_valid_d = act_n && ({1'b0, x_n} < FB_X_LIM) && ({1'b0, y_n} < FB_Y_LIM);
            sol_d      = (h_n == '0);
            sof_d      = (h_n == '0) && (v_n == '0);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops sample together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_q        <= '0;
            v_q        <= '0;
            xcnt_q     <= '0;
            xsub_q     <= '0;
            ycnt_q     <= '0;
            ysub_q     <= '0;
            x_q        <= '0;
            y_q        <= '0;
            hsync_q    <= ~HSYNC_POL;
            vsync_q    <= ~VSYNC_POL;
            active_q   <= 1'b0;
            fb_valid_q <= 1'b0;
            sol_q      <= 1'b0;
            sof_q      <= 1'b0;
        end else begin
            h_q        <= h_d;
            v_q        <= v_d;
            xcnt_q     <= xcnt_d;
            xsub_q     <= xsub_d;
            ycnt_q     <= ycnt_d;
            ysub_q     <= ysub_d;
            x_q        <= x_d;
            y_q        <= y_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            active_q   <= active_d;
            fb_valid_q <= fb_valid_d;
            sol_q      <= sol_d;
            sof_q      <= sof_d;
        end
    end

    assign hcount   = h_q;
    assign vcount   = v_q;
    assign hsync    = hsync_q;
    assign vsync    = vsync_q;
    assign active   = active_q;
    assign x        = x_q;
    assign y        = y_q;
    assign fb_valid = fb_valid_q;
    assign sol      = sol_q;
    assign sof      = sof_q;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: a positive- and a negative-polarity instance run
// on identical stimulus and are checked against a closed-form raster decode.
module tb_vga_timing;

    localparam int CW = 12;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic ce    = 1'b0;

    logic [CW-1:0] hc_p, vc_p, x_p, y_p, hc_n, vc_n, x_n, y_n;
    logic hs_p, vs_p, act_p, fb_p, sol_p, sof_p;
    logic hs_n, vs_n, act_n, fb_n, sol_n, sof_n;

    always #5 clk = ~clk;

    vga_timing #(
        .CW(CW), .HFRONT(2), .HSYNCP(3), .HBACK(1), .HLINE(10),
        .VFRONT(1), .VSYNCP(2), .VBACK(1), .VFRAME(8),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .XSCALE(2), .YSCALE(1),
        .FB_X_MAX(1), .FB_Y_MAX(4)
    ) u_dut_p (
        .clk(clk), .reset(reset), .ce(ce),
        .hcount(hc_p), .vcount(vc_p), .hsync(hs_p), .vsync(vs_p),
        .active(act_p), .x(x_p), .y(y_p), .fb_valid(fb_p),
        .sol(sol_p), .sof(sof_p)
    );

    vga_timing #(
        .CW(CW), .HFRONT(2), .HSYNCP(3), .HBACK(1), .HLINE(10),
        .VFRONT(1), .VSYNCP(2), .VBACK(1), .VFRAME(8),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .XSCALE(2), .YSCALE(1),
        .FB_X_MAX(1), .FB_Y_MAX(4)
    ) u_dut_n (
        .clk(clk), .reset(reset), .ce(ce),
        .hcount(hc_n), .vcount(vc_n), .hsync(hs_n), .vsync(vs_n),
        .active(act_n), .x(x_n), .y(y_n), .fb_valid(fb_n),
        .sol(sol_n), .sof(sof_n)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference raster position and a flag for "reset seen, no ce since".
    int mh = 0;
    int mv = 0;
    bit after_rst = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic ce_v);
        ce = ce_v;
        @(posedge clk);
        #1;
        if (ce_v && !reset) begin
            after_rst = 1'b0;
            if (mh == 9) begin
                mh = 0;
                mv = (mv == 7) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
        end
    endtask

    // Closed-form expectations for the bench geometry: HSTART=6, VSTART=4.
    task automatic check_all(input string tag);
        int ehs, evs, eact, ex, ey, efb, esol, esof;
        ehs  = (mh >= 2 && mh < 5) ? 1 : 0;
        evs  = (mv >= 1 && mv < 3) ? 1 : 0;
        eact = (mh >= 6 && mv >= 4) ? 1 : 0;
        ex   = eact ? (mh - 6) / 2 : 0;
        ey   = eact ? (mv - 4) : 0;
        efb  = (eact && ex < 1 && ey < 4) ? 1 : 0;
        esol = (!after_rst && mh == 0) ? 1 : 0;
        esof = (!after_rst && mh == 0 && mv == 0) ? 1 : 0;

        chk({tag, ".p.hcount"}, 32'(hc_p), mh);
        chk({tag, ".p.vcount"}, 32'(vc_p), mv);
        chk({tag, ".p.hsync"}, 32'(hs_p), ehs);
        chk({tag, ".p.vsync"}, 32'(vs_p), evs);
        chk({tag, ".p.active"}, 32'(act_p), eact);
        chk({tag, ".p.x"}, 32'(x_p), ex);
        chk({tag, ".p.y"}, 32'(y_p), ey);
        chk({tag, ".p.fb_valid"}, 32'(fb_p), efb);
        chk({tag, ".p.sol"}, 32'(sol_p), esol);
        chk({tag, ".p.sof"}, 32'(sof_p), esof);

        chk({tag, ".n.hcount"}, 32'(hc_n), mh);
        chk({tag, ".n.vcount"}, 32'(vc_n), mv);
        chk({tag, ".n.hsync"}, 32'(hs_n), 1 - ehs);
        chk({tag, ".n.vsync"}, 32'(vs_n), 1 - evs);
        chk({tag, ".n.active"}, 32'(act_n), eact);
        chk({tag, ".n.x"}, 32'(x_n), ex);
        chk({tag, ".n.y"}, 32'(y_n), ey);
        chk({tag, ".n.fb_valid"}, 32'(fb_n), efb);
        chk({tag, ".n.sol"}, 32'(sol_n), esol);
        chk({tag, ".n.sof"}, 32'(sof_n), esof);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sol_cnt, sof_cnt, first_sof, last_sol, act_cnt, hs_cnt, vs_cnt;
        int xt[4];
        int fbt[4];
        xt  = '{0, 0, 1, 1};
        fbt = '{1, 1, 0, 0};
        sol_cnt = 0; sof_cnt = 0; first_sof = -1; last_sol = -1;
        act_cnt = 0; hs_cnt = 0; vs_cnt = 0;

        // Reset, including a clock edge with ce high while reset is held.
        #2 reset = 1'b1;
        #10;
        check_all("reset");
        tick(1'b0);
        check_all("reset_ce0");
        tick(1'b1);
        check_all("reset_ce1");
        reset = 1'b0;
        check_all("release");
        tick(1'b0);
        check_all("idle_after_release");

        // Two full frames with ce held high.
        for (int i = 1; i <= 160; i++) begin
            tick(1'b1);
            check_all("run");
            if (i == 1) begin
                chk("first_step_h", 32'(hc_p), 1);
                chk("first_step_v", 32'(vc_p), 0);
            end
            if (sol_p === 1'b1) begin
                sol_cnt++;
                if (last_sol >= 0) chk("sol_period", 32'(i - last_sol), 10);
                last_sol = i;
            end
            if (sof_p === 1'b1) begin
                sof_cnt++;
                if (first_sof < 0) first_sof = i;
            end
            if (act_p === 1'b1) act_cnt++;
            if (hs_p === 1'b1) hs_cnt++;
            if (vs_p === 1'b1) vs_cnt++;
            if (mv == 4 && mh >= 6) begin
                chk("line4_x", 32'(x_p), xt[mh-6]);
                chk("line4_fb", 32'(fb_p), fbt[mh-6]);
            end
        end
        chk("sol_count", 32'(sol_cnt), 16);
        chk("sof_count", 32'(sof_cnt), 2);
        chk("first_sof_cycle", 32'(first_sof), 80);
        chk("active_count", 32'(act_cnt), 32);
        chk("hsync_count", 32'(hs_cnt), 48);
        chk("vsync_count", 32'(vs_cnt), 40);

        // Freeze at the frame origin: sol and sof must be held while ce is low.
        tick(1'b0);
        check_all("freeze_origin1");
        chk("freeze_sof", 32'(sof_p), 1);
        tick(1'b0);
        check_all("freeze_origin2");
        chk("freeze_sol", 32'(sol_p), 1);
        tick(1'b1);
        check_all("thaw_origin");

        // ce pattern 1,0,0,1 in the middle of the sync pulse.
        tick(1'b1);
        check_all("toggle_1a");
        tick(1'b0);
        check_all("toggle_0a");
        tick(1'b0);
        check_all("toggle_0b");
        tick(1'b1);
        check_all("toggle_1b");

        // Seek to hcount=7, vcount=5 and reset asynchronously mid-cycle.
        for (int i = 0; i < 200 && !(mh == 7 && mv == 5); i++) begin
            tick(1'b1);
            check_all("seek");
        end
        chk("pre_reset_x", 32'(x_p), 0);
        chk("pre_reset_y", 32'(y_p), 1);
        #3 reset = 1'b1;
        #1;
        mh = 0;
        mv = 0;
        after_rst = 1'b1;
        check_all("async_reset");
        tick(1'b1);
        check_all("async_reset_held");
        reset = 1'b0;
        check_all("async_release");
        tick(1'b1);
        check_all("restart");
        chk("restart_h", 32'(hc_p), 1);
        for (int i = 0; i < 20; i++) begin
            tick(1'b1);
            check_all("after_restart");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter CW, default 12: width of all counter and coordinate ports.
REQ-002 Parameters HFRONT 48, HSYNCP 112, HBACK 248, HLINE 1688: horizontal front porch, sync, back porch and total line length, in pixels.
REQ-003 Parameters VFRONT 1, VSYNCP 3, VBACK 38, VFRAME 1066: vertical front porch, sync, back porch and total frame length, in lines.
REQ-004 Parameters HSYNC_POL 1, VSYNC_POL 1: asserted level of hsync and vsync (1 means active-high).
REQ-005 Parameters XSCALE 1, YSCALE 1 (range 1..8): pixel and line replication factors.
REQ-006 Parameters FB_X_MAX 1280, FB_Y_MAX 1024: framebuffer width and height, in scaled pixels.
REQ-007 clk  in  1  pixel clock; the block's only clock.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 ce  in  1  pixel enable; all state advances only in cycles where ce=1.
REQ-010 hcount  out  CW  horizontal position, 0..HLINE-1.
REQ-011 vcount  out  CW  vertical position, 0..VFRAME-1.
REQ-012 hsync, vsync  out  1 each  sync pulses at the configured polarity.
REQ-013 active  out  1  high inside the visible region.
REQ-014 x, y  out  CW each  scaled framebuffer coordinate.
REQ-015 fb_valid  out  1  active and (x,y) lies inside the framebuffer.
REQ-016 sol, sof  out  1 each  start-of-line and start-of-frame strobes.

Function
REQ-017 Region order on each axis SHALL be: front porch, sync, back porch, active; HSTART = HFRONT+HSYNCP+HBACK; VSTART = VFRONT+VSYNCP+VBACK.
REQ-018 When ce=1, hcount SHALL increment, wrapping from HLINE-1 to 0; vcount SHALL increment only on that wrap, wrapping from VFRAME-1 to 0.
REQ-019 All outputs SHALL be registered and mutually aligned: in every cycle, every decoded output corresponds to the hcount/vcount values presented in that same cycle, with no lag.
REQ-020 hsync SHALL equal HSYNC_POL when HFRONT <= hcount < HFRONT+HSYNCP, and !HSYNC_POL otherwise; vsync SHALL follow the same rule using the V parameters and VSYNC_POL.
REQ-021 active SHALL be high when hcount >= HSTART and vcount >= VSTART.
REQ-022 x SHALL be 0 at hcount = HSTART and SHALL increment once per XSCALE active pixels, using an internal replication sub-counter.
REQ-023 y SHALL be 0 on line VSTART and SHALL increment once per YSCALE active lines, using an internal line sub-counter.
REQ-024 x and y SHALL be 0 whenever active=0.
REQ-025 fb_valid SHALL equal active & (x < FB_X_MAX) & (y < FB_Y_MAX).
REQ-026 x and y SHALL saturate at 2^CW-1 and never wrap.
REQ-027 sol SHALL be high exactly when hcount=0; sof SHALL be high exactly when hcount=0 and vcount=0.
REQ-028 When ce=0, every output and all internal state SHALL hold; sol and sof SHALL repeat for as long as ce stays low.
REQ-029 Frame wrap and line wrap SHALL take effect in the same ce cycle, with no extra idle cycle.
REQ-030 Elaboration SHALL fail if HSTART >= HLINE, if VSTART >= VFRAME, if either scale factor is outside 1..8, or if HLINE or VFRAME exceeds 2^CW.

Reset
REQ-031 While reset=1: hcount=0, vcount=0, x=0, y=0, active=0, fb_valid=0, sol=0, sof=0, hsync=!HSYNC_POL and vsync=!VSYNC_POL.
REQ-032 After reset deasserts, the first ce=1 cycle SHALL advance the counters to (1,0); the first sof SHALL occur at the first frame wrap.
REQ-033 Reset asserted mid-frame SHALL force the REQ-031 values immediately, independent of clk and ce.

Verification
Bench parameters: HFRONT=2, HSYNCP=3, HBACK=1, HLINE=10, VFRONT=1, VSYNCP=2, VBACK=1, VFRAME=8, XSCALE=2, YSCALE=1, FB_X_MAX=1, FB_Y_MAX=4, polarities 1.
REQ-034 ce held at 1 for one line -> hsync high for hcount 2..4; active only on lines >= 4; sol high once every 10 cycles.
REQ-035 Line 4, hcount 6..9 -> x = 0,0,1,1; fb_valid = 1,1,0,0.
REQ-036 Run one full frame -> vsync high on vcount 1..2; sof high once per 80 ce cycles, at (0,0); y = 0..3 on lines 4..7.
REQ-037 Toggle ce 1,0,0,1 -> outputs frozen during the ce=0 cycles, and a sol or sof present when the freeze starts is held for that whole time.
REQ-038 Assert reset asynchronously at hcount=7, vcount=5 -> all outputs take REQ-031 values before the next clk edge; on release, counting restarts from (0,0).
REQ-039 Rerun with HSYNC_POL=0 and VSYNC_POL=0 -> sync waveforms inverted; all other outputs bit-identical to the positive-polarity run.
